// File: rtl/lane_seg_pkg.sv
// ---------------------------------------------------------------------------
// lane_seg_pkg
// Purpose : shared definitions for the lane segment arbiter: default lane
//           count and beat width, the arbiter FSM state type and the lane
//           index type used for grant, pointer and tid.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package lane_seg_pkg;

    localparam int NUM_LANES  = 5;
    localparam int DATA_W     = 76;
    localparam int LANE_IDX_W = 3;

    typedef logic [LANE_IDX_W-1:0] lane_idx_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_t;

endpackage : lane_seg_pkg

// File: rtl/lane_segment_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Purpose : combinational round-robin search. Returns the first set bit of
//           req examining ptr, ptr+1, ... wrapping modulo N.
// Ports   : req   in  N    request vector
//           ptr   in  3    index searched first
//           idx   out 3    selected lane (0 when nothing found)
//           found out 1    req has at least one bit set
// ---------------------------------------------------------------------------
module rr_pick
    import lane_seg_pkg::*;
#(
    parameter int N = lane_seg_pkg::NUM_LANES
) (
    input  logic [N-1:0] req,
    input  lane_idx_t    ptr,
    output lane_idx_t    idx,
    output logic         found
);

    // Walk the offsets from farthest to nearest so the nearest hit from ptr
    // is the last assignment and therefore wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                idx   = lane_idx_t'((int'(ptr) + k) % N);
                found = 1'b1;
            end
        end
    end

endmodule : rr_pick

// File: rtl/lane_segment_arbiter.sv
// ---------------------------------------------------------------------------
// lane_segment_arbiter
// Purpose : merges NUM_LANES AXI-stream segment lanes onto one output with
//           packet-granular round-robin arbitration and a one-stage output
//           register (1-cycle latency from accept to m_axis_*).
// Build   : define LANE_SEG_ARB_STATS_EN to add per-lane completed-segment
//           counters on pkt_cnt.
// Ports   : clk, rst            clock, synchronous active-high reset
//           s_axis_tdata/tvalid/tlast/tready   lane inputs (lane i at slice i)
//           lane_en             lanes allowed to win arbitration
//           m_axis_tdata/tvalid/tlast/tid/tready   merged output
//           busy                high while a segment is being transferred
//           pkt_cnt             per-lane segment counters (stats build only)
// ---------------------------------------------------------------------------
module lane_segment_arbiter
    import lane_seg_pkg::*;
#(
    parameter int NUM_LANES = lane_seg_pkg::NUM_LANES,
    parameter int DATA_W    = lane_seg_pkg::DATA_W,
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_LANES*DATA_W-1:0] s_axis_tdata,
    input  logic [NUM_LANES-1:0]        s_axis_tvalid,
    input  logic [NUM_LANES-1:0]        s_axis_tlast,
    output logic [NUM_LANES-1:0]        s_axis_tready,
    input  logic [NUM_LANES-1:0]        lane_en,
    output logic [DATA_W-1:0]           m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast,
    output logic [LANE_IDX_W-1:0]       m_axis_tid,
    input  logic                        m_axis_tready,
    output logic                        busy
`ifdef LANE_SEG_ARB_STATS_EN
    ,
    output logic [NUM_LANES*CNT_W-1:0]  pkt_cnt
`endif
);

    // The lane index is 3 bits wide, so more than 8 lanes cannot be encoded.
    if (NUM_LANES < 1 || NUM_LANES > 8 || CNT_W < 1) begin : g_param_check
        $error("lane_segment_arbiter: NUM_LANES must be 1..8 and CNT_W >= 1");
    end

    arb_state_t           r_state, w_state_nxt;
    lane_idx_t            r_gnt, w_gnt_nxt;
    lane_idx_t            r_ptr, w_ptr_nxt;
    logic [NUM_LANES-1:0] w_req;
    logic [NUM_LANES-1:0] w_tready;
    lane_idx_t            w_pick;
    logic                 w_found;
    logic                 w_out_rdy;
    logic                 w_acc;
    logic [DATA_W-1:0]    w_gnt_data;

    logic [DATA_W-1:0]    r_tdata;
    logic                 r_tvalid;
    logic                 r_tlast;
    lane_idx_t            r_tid;

    // lane_en only gates new grants; a granted lane finishes its segment
    // even if its enable drops.
    assign w_req      = s_axis_tvalid & lane_en;
    // Output register can take a beat when empty or being drained this cycle.
    assign w_out_rdy  = ~r_tvalid | m_axis_tready;
    assign w_gnt_data = s_axis_tdata[int'(r_gnt)*DATA_W +: DATA_W];

    rr_pick #(.N(NUM_LANES)) u_rr_pick (
        .req   (w_req),
        .ptr   (r_ptr),
        .idx   (w_pick),
        .found (w_found)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_ptr_nxt   = r_ptr;
        w_tready    = '0;
        w_acc       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_gnt_nxt   = w_pick;
                    w_state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                w_tready[r_gnt] = w_out_rdy;
                w_acc           = w_out_rdy & s_axis_tvalid[r_gnt];
                if (w_acc & s_axis_tlast[r_gnt]) begin
                    w_ptr_nxt   = (r_gnt == lane_idx_t'(NUM_LANES - 1)) ? '0 : r_gnt + 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_gnt    <= '0;
            r_ptr    <= '0;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tid    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ptr   <= w_ptr_nxt;
            if (w_acc) begin
                r_tdata  <= w_gnt_data;
                r_tvalid <= 1'b1;
                r_tlast  <= s_axis_tlast[r_gnt];
                r_tid    <= r_gnt;
            end else if (m_axis_tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign s_axis_tready = w_tready;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tid    = r_tid;
    assign busy          = (r_state == ST_XFER);

`ifdef LANE_SEG_ARB_STATS_EN
    // Counted at the output handshake so a segment abandoned by reset is
    // never counted.
    logic [NUM_LANES-1:0][CNT_W-1:0] r_pkt_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (r_tvalid & m_axis_tready & r_tlast & (r_tid == lane_idx_t'(i))) begin
                    r_pkt_cnt[i] <= r_pkt_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign pkt_cnt = r_pkt_cnt;
`endif

endmodule : lane_segment_arbiter

// File: tb/tb_lane_segment_arbiter.sv
module tb_lane_segment_arbiter;
  localparam int NL = 5;
  localparam int DW = 76;
  localparam int CW = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [2:0]    tid;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NL*DW-1:0] s_tdata = '0;
  logic [NL-1:0]   s_tvalid = '0, s_tlast = '0, s_tready, lane_en = '1;
  logic [DW-1:0]   m_tdata;
  logic            m_tvalid, m_tlast, busy;
  logic            m_tready = 1'b1;
  logic [2:0]      m_tid;
`ifdef LANE_SEG_ARB_STATS_EN
  logic [NL*CW-1:0] pkt_cnt;
`endif

  beat_t lane_q[NL][$];
  beat_t exp_q[$];
  bit    mid[NL];
  int    lane_out[NL];
  int    checks = 0, errors = 0, cyc = 0, seq = 0;
  bit    gaps_on = 0, rand_rdy = 0, force_rdy = 1, gap_mode = 0, lat_arm = 0;
  int    busy_cyc = -1, out_cyc = -1;

  always #5 clk = ~clk;

  lane_segment_arbiter #(.NUM_LANES(NL), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready), .lane_en(lane_en),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .m_axis_tid(m_tid), .m_axis_tready(m_tready), .busy(busy)
`ifdef LANE_SEG_ARB_STATS_EN
    , .pkt_cnt(pkt_cnt)
`endif
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add_seg(input int lane, input int n, input bit push_exp);
    beat_t b;
    logic [95:0] r;
    for (int k = 0; k < n; k++) begin
      r = {$urandom, $urandom, $urandom};
      b.data = r[DW-1:0];
      b.data[DW-1 -: 12] = 12'(seq);
      seq++;
      b.last = (k == n - 1);
      b.tid  = 3'(lane);
      lane_q[lane].push_back(b);
      if (push_exp) exp_q.push_back(b);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    gaps_on = 0; rand_rdy = 0; force_rdy = 1; gap_mode = 0; lat_arm = 0;
    lane_en = '1;
    exp_q.delete();
    for (int l = 0; l < NL; l++) begin lane_q[l].delete(); mid[l] = 0; end
    repeat (2) @(negedge clk);
    for (int l = 0; l < NL; l++) begin lane_q[l].delete(); mid[l] = 0; lane_out[l] = 0; end
    rst = 1'b0;
  endtask

  task automatic wait_exp(input int n_left, input int budget);
    int k = 0;
    while ((exp_q.size() > n_left || busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("drain_left", exp_q.size(), n_left);
    repeat (4) @(negedge clk);
    chk("idle_after_drain", busy, 0);
  endtask

  task automatic wait_out(input int lane, input int n);
    int k = 0;
    while (lane_out[lane] < n && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("wait_out", lane_out[lane] >= n, 1);
  endtask

  // Reference model: plain packet round robin over enabled lanes holding
  // pending segments, starting from lane 0 after reset.
  task automatic rand_round(input int dis_lane);
    beat_t mq[NL][$];
    beat_t b;
    int ptr, nseg, pick;
    do_reset();
    if (dis_lane >= 0) lane_en[dis_lane] = 1'b0;
    for (int l = 0; l < NL; l++) begin
      nseg = (l == dis_lane) ? $urandom_range(1, 2) : $urandom_range(0, 3);
      for (int s = 0; s < nseg; s++) add_seg(l, $urandom_range(1, 5), 0);
      mq[l] = lane_q[l];
    end
    ptr = 0;
    pick = 0;
    while (pick >= 0) begin
      pick = -1;
      for (int k = 0; k < NL; k++)
        if (pick < 0 && lane_en[(ptr + k) % NL] && mq[(ptr + k) % NL].size() > 0) pick = (ptr + k) % NL;
      if (pick >= 0) begin
        do begin b = mq[pick].pop_front(); exp_q.push_back(b); end while (!b.last);
        ptr = (pick + 1) % NL;
      end
    end
    gaps_on = 1; rand_rdy = 1;
    wait_exp(0, 3000);
    if (dis_lane >= 0) begin
      chk("disabled_lane_silent", lane_out[dis_lane], 0);
      foreach (mq[dis_lane][i]) exp_q.push_back(mq[dis_lane][i]);
      lane_en[dis_lane] = 1'b1;
      wait_exp(0, 3000);
    end
  endtask

  // Lane sources: first beat of a segment is always offered so every lane
  // with pending data requests at arbitration; gaps only inside segments.
  initial begin
    bit acc[NL];
    beat_t b;
    forever begin
      @(negedge clk);
      for (int l = 0; l < NL; l++) acc[l] = s_tvalid[l] && s_tready[l] && !rst;
      @(posedge clk);
      for (int l = 0; l < NL; l++)
        if (acc[l] && lane_q[l].size() > 0) begin
          b = lane_q[l].pop_front();
          mid[l] = !b.last;
        end
      #1;
      m_tready = rand_rdy ? ($urandom_range(0, 2) != 0) : force_rdy;
      for (int l = 0; l < NL; l++) begin
        if (lane_q[l].size() > 0) begin
          s_tvalid[l] = (mid[l] && gaps_on) ? ($urandom_range(0, 3) != 0) : 1'b1;
          s_tdata[l*DW +: DW] = lane_q[l][0].data;
          s_tlast[l] = lane_q[l][0].last;
        end else begin
          s_tvalid[l] = 1'b0;
          s_tlast[l]  = 1'b0;
        end
      end
    end
  end

  always @(posedge clk) cyc++;

  // Monitor / scoreboard.
  initial begin
    beat_t b, pb;
    bit pstall = 0, plast = 0;
    int lcyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pstall = 0; plast = 0;
      end else begin
        chk("tready_onehot", $countones(s_tready) <= 1, 1);
        if (pstall) chk("stall_hold", {m_tvalid, m_tid, m_tlast, m_tdata}, {1'b1, pb.tid, pb.last, pb.data});
        if (m_tvalid && !m_tready) chk("stall_sready", s_tready, 0);
        if (lat_arm && busy && busy_cyc < 0) busy_cyc = cyc;
        if (lat_arm && m_tvalid && out_cyc < 0) out_cyc = cyc;
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat actual tid=%0d last=%0b data=%0h expected none", m_tid, m_tlast, m_tdata);
          end else begin
            b = exp_q.pop_front();
            chk("beat", {m_tid, m_tlast, m_tdata}, {b.tid, b.last, b.data});
          end
          if (m_tid < NL) lane_out[m_tid]++;
          if (gap_mode && plast) chk("seg_gap", cyc - lcyc, 2);
          plast = m_tlast;
          if (m_tlast) lcyc = cyc;
        end
        pstall = m_tvalid && !m_tready;
        pb.data = m_tdata; pb.last = m_tlast; pb.tid = m_tid;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    // reset values
    repeat (3) @(negedge clk);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tid", m_tid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sready", s_tready, 0);
`ifdef LANE_SEG_ARB_STATS_EN
    chk("rst_pkt_cnt", pkt_cnt, 0);
`endif

    // lane 2 alone, 4 beats, latency of 1 after grant
    do_reset();
    lat_arm = 1; busy_cyc = -1; out_cyc = -1;
    add_seg(2, 4, 1);
    wait_exp(0, 200);
    chk("first_beat_latency", out_cyc - busy_cyc, 1);
    chk("lane2_beats", lane_out[2], 4);
    lat_arm = 0;

    // all lanes, 3-beat segments: order 0..4,0..4 with one idle cycle
    do_reset();
    gap_mode = 1;
    for (int r = 0; r < 2; r++)
      for (int l = 0; l < NL; l++) add_seg(l, 3, 1);
    wait_exp(0, 500);
    gap_mode = 0;

    // lane 1 stalled 5 cycles mid-segment
    do_reset();
    add_seg(1, 6, 1);
    wait_out(1, 2);
    force_rdy = 0;
    repeat (5) @(negedge clk);
    force_rdy = 1;
    wait_exp(0, 200);
    chk("lane1_beats", lane_out[1], 6);

    // lane_en[3] dropped mid-segment
    do_reset();
    add_seg(3, 6, 1);
    add_seg(3, 2, 0);
    wait_out(3, 1);
    lane_en[3] = 1'b0;
    wait_exp(0, 200);
    repeat (6) @(negedge clk);
    chk("lane3_seg_complete", lane_out[3], 6);
    chk("lane3_not_regranted", busy, 0);
    for (int i = 6; i < 8; i++) ;
    foreach (lane_q[3][i]) exp_q.push_back(lane_q[3][i]);
    lane_en[3] = 1'b1;
    wait_exp(0, 200);
    chk("lane3_after_reenable", lane_out[3], 8);

    // reset mid-segment; lane 3 first so ptr is 4 before the abort
    do_reset();
    add_seg(3, 1, 1);
    wait_exp(0, 100);
    add_seg(0, 6, 1);
    wait_out(0, 2);
    rst = 1'b1;
    exp_q.delete();
    for (int l = 0; l < NL; l++) begin lane_q[l].delete(); mid[l] = 0; end
    @(negedge clk);
    chk("rst_mid_tvalid", m_tvalid, 0);
    chk("rst_mid_busy", busy, 0);
    for (int l = 0; l < NL; l++) begin lane_q[l].delete(); mid[l] = 0; end
    rst = 1'b0;
    add_seg(1, 2, 1);   // ptr back at 0: lane 1 wins over lane 4
    add_seg(4, 3, 1);
    wait_exp(0, 200);
    chk("post_rst_lane4", lane_out[4], 3);

    // randomized rounds against the reference model
    rand_round(-1);
    rand_round(-1);
    rand_round($urandom_range(0, NL - 1));
    rand_round($urandom_range(0, NL - 1));

`ifdef LANE_SEG_ARB_STATS_EN
    do_reset();
    for (int s = 0; s < 300; s++) add_seg(0, 1, 1);
    wait_exp(0, 2000);
    chk("pkt_cnt_lane0_wrap", pkt_cnt[CW-1:0], (300 % (1 << CW)));
    chk("pkt_cnt_others", pkt_cnt[NL*CW-1:CW], 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
